// File: rtl/img_pkg.sv
// Shared pixel/gradient types and 1280x720 video timing constants for the
// med_filter -> sobel_edge stream.
package img_pkg;
  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int H_TOTAL  = 1650;
  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int V_TOTAL  = 750;

  typedef logic [7:0]         pix_t;
  typedef logic signed [10:0] grad_t;

  function automatic grad_t to_g(pix_t p);
    return grad_t'({3'b000, p});
  endfunction

  // |g| never overflows: gradients are bounded to +/-1020.
  function automatic logic [10:0] abs_g(grad_t g);
    return g[10] ? 11'(-g) : 11'(g);
  endfunction
endpackage

// File: rtl/win3x3_gen.sv
// Line buffers, column/row tracking and the 3x3 pixel window (stage S1).
// Window index is row*3+col; row 0 = oldest line, col 0 = oldest pixel.
module win3x3_gen
  import img_pkg::*;
#(
  parameter int IMG_WIDTH = 1280
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_vsync,
  input  logic            i_hsync,
  input  logic            i_valid,
  input  logic [7:0]      i_data,
  output logic [8:0][7:0] o_win,
  output logic            o_border,
  output logic            o_vsync,
  output logic            o_hsync,
  output logic            o_valid
);
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int AW = $clog2(IMG_WIDTH);

  logic [CW-1:0]   r_col;
  logic [10:0]     r_row;
  logic            r_vld_d;
  pix_t            r_lb0 [IMG_WIDTH];
  pix_t            r_lb1 [IMG_WIDTH];
  logic [8:0][7:0] r_win;
  logic            r_border, r_vs, r_hs, r_vld;

  // Sync pulses clear the position in the same cycle, so a pixel that
  // coincides with sync is seen at column 0 (and row 0 on vsync).
  logic          w_clr;
  logic [CW-1:0] w_c;
  logic [10:0]   w_r;
  logic          w_inb;
  logic [AW-1:0] w_addr;
  assign w_clr  = i_hsync | i_vsync;
  assign w_c    = w_clr ? '0 : r_col;
  assign w_r    = i_vsync ? '0 : r_row;
  assign w_inb  = w_c < CW'(IMG_WIDTH);
  assign w_addr = w_c[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_vld_d <= 1'b0;
    end else begin
      if (i_valid)    r_col <= (w_c == CW'(IMG_WIDTH)) ? w_c : w_c + 1'b1;
      else if (w_clr) r_col <= '0;
      r_vld_d <= i_valid;
      if (i_vsync) r_row <= '0;
      else if (r_vld_d && !i_valid && r_row != 11'd2047) r_row <= r_row + 1'b1;
    end
  end

  // Read-before-write: lb1 takes the value lb0 held before this write.
  always_ff @(posedge clk) begin
    if (i_valid && w_inb) begin
      r_lb0[w_addr] <= i_data;
      r_lb1[w_addr] <= r_lb0[w_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win    <= '0;
      r_border <= 1'b0;
      r_vs     <= 1'b0;
      r_hs     <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      if (i_valid) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[2] <= w_inb ? r_lb1[w_addr] : '0;
        r_win[5] <= w_inb ? r_lb0[w_addr] : '0;
        r_win[8] <= i_data;
      end
      r_border <= (w_r < 11'd2) || (w_c < CW'(2)) || !w_inb;
      r_vs     <= i_vsync;
      r_hs     <= i_hsync;
      r_vld    <= i_valid;
    end
  end

  assign o_win    = r_win;
  assign o_border = r_border;
  assign o_vsync  = r_vs;
  assign o_hsync  = r_hs;
  assign o_valid  = r_vld;
endmodule

// File: rtl/sobel_edge.sv
// Sobel |Gx|+|Gy| edge detector with per-frame threshold; binary edge map
// out with the input framing delayed by a fixed 4 cycles.
module sobel_edge
  import img_pkg::*;
#(
  parameter int         IMG_WIDTH = 1280,
  parameter logic [7:0] EDGE_VAL  = 8'hFF,
  parameter logic [7:0] BG_VAL    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] edge_thresh,
  input  logic        pre_img_vsync,
  input  logic        pre_img_hsync,
  input  logic        pre_img_valid,
  input  logic [7:0]  pre_img_data,
  output logic        post_img_vsync,
  output logic        post_img_hsync,
  output logic        post_img_valid,
  output logic [7:0]  post_img_data
);
  localparam int LAT = 4;

  logic [8:0][7:0] w_win;
  logic            w_border, w_vs1, w_hs1, w_vld1;

  win3x3_gen #(.IMG_WIDTH(IMG_WIDTH)) u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_vsync (pre_img_vsync),
    .i_hsync (pre_img_hsync),
    .i_valid (pre_img_valid),
    .i_data  (pre_img_data),
    .o_win   (w_win),
    .o_border(w_border),
    .o_vsync (w_vs1),
    .o_hsync (w_hs1),
    .o_valid (w_vld1)
  );

  grad_t w_gx, w_gy;
  always_comb begin
    w_gx = (to_g(w_win[2]) + (to_g(w_win[5]) <<< 1) + to_g(w_win[8]))
         - (to_g(w_win[0]) + (to_g(w_win[3]) <<< 1) + to_g(w_win[6]));
    w_gy = (to_g(w_win[6]) + (to_g(w_win[7]) <<< 1) + to_g(w_win[8]))
         - (to_g(w_win[0]) + (to_g(w_win[1]) <<< 1) + to_g(w_win[2]));
  end

  // r_sync[k] = {vsync, hsync, valid} as seen after stage k.
  logic [LAT:2][2:0] r_sync;
  grad_t             r_gx, r_gy;
  logic [10:0]       r_mag, r_thr;
  logic              r_bd2, r_bd3, r_vs_d;
  logic [7:0]        r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_gx   <= '0;
      r_gy   <= '0;
      r_mag  <= '0;
      r_thr  <= '0;
      r_bd2  <= 1'b0;
      r_bd3  <= 1'b0;
      r_vs_d <= 1'b0;
      r_data <= '0;
    end else begin
      r_vs_d <= pre_img_vsync;
      if (pre_img_vsync && !r_vs_d) r_thr <= edge_thresh;
      r_sync <= {r_sync[LAT-1:2], {w_vs1, w_hs1, w_vld1}};
      r_gx   <= w_gx;
      r_gy   <= w_gy;
      r_bd2  <= w_border;
      r_mag  <= abs_g(r_gx) + abs_g(r_gy);
      r_bd3  <= r_bd2;
      if (!r_sync[3][0])                r_data <= '0;
      else if (!r_bd3 && r_mag >= r_thr) r_data <= EDGE_VAL;
      else                              r_data <= BG_VAL;
    end
  end

  assign post_img_vsync = r_sync[LAT][2];
  assign post_img_hsync = r_sync[LAT][1];
  assign post_img_valid = r_sync[LAT][0];
  assign post_img_data  = r_data;
endmodule
